bullet_pool: RTL and testbench

//  Multi-slot projectile manager for one shooter, successor of the single-bullet controller.

---
 rtl/bullet_pool.sv | 163 ++++++++++++++++
 tb/tb_bullet_pool.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// rtl/bullet_pool.sv - multi-slot projectile manager with cooldown, hit detection and despawn
module bullet_pool #(
    parameter int NUM_BULLETS = 4,
    parameter int DIR         = 0,
    parameter int STEP_X      = 8,
    parameter int COOLDOWN    = 16,
    parameter int MAP_X       = 320,
    parameter int PLAYER_X    = 16,
    parameter int PLAYER_Y    = 32,
    parameter int SQUAT_Y     = 16,
    parameter int BULLET_X    = 4,
    parameter int BULLET_Y    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tick,
    input  logic                             fire,
    input  logic                             block,
    input  logic signed [10:0]               xShooter,
    input  logic signed [9:0]                yShooter,
    input  logic signed [10:0]               xTarget,
    input  logic signed [9:0]                yTarget,
    input  logic                             targetSquat,
    output logic [NUM_BULLETS*11-1:0]        bx,
    output logic [NUM_BULLETS*10-1:0]        by,
    output logic [NUM_BULLETS-1:0]           alive,
    output logic                             hit,
    output logic [$clog2(NUM_BULLETS+1)-1:0] hit_count,
    output logic                             cooling
);

    localparam int CW  = $clog2(NUM_BULLETS + 1);
    localparam int IW  = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam int CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    // Geometry constants, all in the 13-bit signed compare domain
    localparam logic signed [12:0] STEP     = 13'(STEP_X);
    localparam logic signed [12:0] HIT_X    = 13'(PLAYER_X + BULLET_X);
    localparam logic signed [12:0] HIT_Y_ST = 13'(PLAYER_Y + BULLET_Y);
    localparam logic signed [12:0] HIT_Y_SQ = 13'(SQUAT_Y + BULLET_Y);
    localparam logic signed [12:0] X_MIN    = 13'(BULLET_X - MAP_X);
    localparam logic signed [12:0] X_MAX    = 13'(MAP_X - BULLET_X);
    localparam logic signed [10:0] SPAWN_OFF = 11'(PLAYER_X + BULLET_X);

    logic signed [10:0] x_r [NUM_BULLETS];
    logic signed [9:0]  y_r [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] alive_r;
    logic [CDW-1:0]         cd_r;
    logic                   hit_r;
    logic [CW-1:0]          hit_cnt_r;

    logic signed [12:0] x_next [NUM_BULLETS];
    logic signed [12:0] dx     [NUM_BULLETS];
    logic signed [12:0] dy     [NUM_BULLETS];
    logic signed [12:0] adx    [NUM_BULLETS];
    logic signed [12:0] ady    [NUM_BULLETS];
    logic signed [12:0] hy;
    logic [NUM_BULLETS-1:0] hit_v;
    logic [NUM_BULLETS-1:0] out_v;
    logic [CW-1:0]          hits_n;
    logic [IW-1:0]          spawn_idx;
    logic                   free_found;
    logic                   spawn_en;
    logic signed [10:0]     spawn_x;

    // Per-slot movement, hit window and off-map tests; hit wins over despawn
    always_comb begin
        hy    = targetSquat ? HIT_Y_SQ : HIT_Y_ST;
        hit_v = '0;
        out_v = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (DIR != 0) begin
                x_next[i] = {{2{x_r[i][10]}}, x_r[i]} + STEP;
            end else begin
                x_next[i] = {{2{x_r[i][10]}}, x_r[i]} - STEP;
            end
            dx[i]  = x_next[i] - {{2{xTarget[10]}}, xTarget};
            dy[i]  = {{3{y_r[i][9]}}, y_r[i]} - {{3{yTarget[9]}}, yTarget};
            adx[i] = dx[i][12] ? -dx[i] : dx[i];
            ady[i] = dy[i][12] ? -dy[i] : dy[i];
            hit_v[i] = alive_r[i] && (adx[i] < HIT_X) && (ady[i] < hy);
            if (DIR != 0) begin
                out_v[i] = alive_r[i] && !hit_v[i] && (x_next[i] > X_MAX);
            end else begin
                out_v[i] = alive_r[i] && !hit_v[i] && (x_next[i] < X_MIN);
            end
        end
    end

    // Number of slots that hit on this tick
    always_comb begin
        hits_n = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            hits_n = hits_n + CW'(hit_v[i]);
        end
    end

    // Lowest free slot, judged on occupancy before this tick's frees
    always_comb begin
        free_found = 1'b0;
        spawn_idx  = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!alive_r[i] && !free_found) begin
                spawn_idx  = IW'(i);
                free_found = 1'b1;
            end
        end
        spawn_en = fire && !block && (cd_r == '0) && free_found;
        spawn_x  = (DIR != 0) ? (xShooter + SPAWN_OFF) : (xShooter - SPAWN_OFF);
    end

    // Slot state, cooldown and hit pulse; everything advances only on tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                x_r[i] <= '0;
                y_r[i] <= '0;
            end
            alive_r   <= '0;
            cd_r      <= '0;
            hit_r     <= 1'b0;
            hit_cnt_r <= '0;
        end else if (tick) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (spawn_en && (spawn_idx == IW'(i))) begin
                    x_r[i]     <= spawn_x;
                    y_r[i]     <= yShooter;
                    alive_r[i] <= 1'b1;
                end else if (alive_r[i]) begin
                    if (hit_v[i] || out_v[i]) begin
                        alive_r[i] <= 1'b0;
                    end else begin
                        x_r[i] <= x_next[i][10:0];
                    end
                end
            end
            if (spawn_en) begin
                cd_r <= CDW'(COOLDOWN);
            end else if (cd_r != '0) begin
                cd_r <= cd_r - CDW'(1);
            end
            hit_r     <= (hits_n != '0);
            hit_cnt_r <= hits_n;
        end else begin
            hit_r     <= 1'b0;
            hit_cnt_r <= '0;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_BULLETS; g++) begin : g_pack
            assign bx[11*g +: 11] = x_r[g];
            assign by[10*g +: 10] = y_r[g];
        end
    endgenerate

    assign alive     = alive_r;
    assign hit       = hit_r;
    assign hit_count = hit_cnt_r;
    assign cooling   = (cd_r != '0);

endmodule

// File: tb/tb_bullet_pool.sv
// tb/tb_bullet_pool.sv - scoreboard bench for bullet_pool
module tb_bullet_pool;

    logic clk = 1'b0;
    logic rst;
    logic tick;
    logic fire;
    logic block;
    logic signed [10:0] xShooter;
    logic signed [9:0]  yShooter;
    logic signed [10:0] xTarget;
    logic signed [9:0]  yTarget;
    logic targetSquat;

    logic [43:0] bx_a, bx_b;
    logic [39:0] by_a, by_b;
    logic [3:0]  alive_a, alive_b;
    logic        hit_a, hit_b;
    logic [2:0]  hc_a, hc_b;
    logic        cool_a, cool_b;

    always #5 clk = ~clk;

    // Instance A: short cooldown; instance B: no cooldown
    bullet_pool #(.NUM_BULLETS(4), .DIR(0), .COOLDOWN(4)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .fire(fire), .block(block),
        .xShooter(xShooter), .yShooter(yShooter), .xTarget(xTarget), .yTarget(yTarget),
        .targetSquat(targetSquat), .bx(bx_a), .by(by_a), .alive(alive_a),
        .hit(hit_a), .hit_count(hc_a), .cooling(cool_a)
    );

    bullet_pool #(.NUM_BULLETS(4), .DIR(0), .COOLDOWN(0)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .fire(fire), .block(block),
        .xShooter(xShooter), .yShooter(yShooter), .xTarget(xTarget), .yTarget(yTarget),
        .targetSquat(targetSquat), .bx(bx_b), .by(by_b), .alive(alive_b),
        .hit(hit_b), .hit_count(hc_b), .cooling(cool_b)
    );

    typedef struct {
        int       tid;
        bit       inst_b;
        logic [3:0] alive;
        bit       hit;
        int       cnt;
        bit       cooling;
        bit       chk_pos;
        int       slot;
        int       x;
        int       y;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;
    logic probe = 1'b0;
    logic mon_d = 1'b0;

    function automatic exp_t mk(int tid, bit b, logic [3:0] al, bit h, int c, bit co,
                                bit p, int s, int x, int y);
        exp_t e;
        e.tid = tid; e.inst_b = b; e.alive = al; e.hit = h; e.cnt = c; e.cooling = co;
        e.chk_pos = p; e.slot = s; e.x = x; e.y = y;
        return e;
    endfunction

    task automatic cmp(input int tid, input string fld, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL test%0d %s: got %0d expected %0d", tid, fld, act, req);
        end
    endtask

    // Output is meaningful in the cycle after a tick or a probe strobe
    always @(posedge clk) mon_d <= tick | probe;

    // Monitor: pop one expectation per presented result and compare
    always @(negedge clk) begin
        if (mon_d) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_underflow: got empty queue expected an entry");
            end else begin
                exp_t e;
                logic [43:0] bxs;
                logic [39:0] bys;
                logic signed [10:0] px;
                logic signed [9:0]  py;
                e   = sb.pop_front();
                bxs = e.inst_b ? bx_b : bx_a;
                bys = e.inst_b ? by_b : by_a;
                cmp(e.tid, "alive", int'(e.inst_b ? alive_b : alive_a), int'(e.alive));
                cmp(e.tid, "hit", int'(e.inst_b ? hit_b : hit_a), int'(e.hit));
                cmp(e.tid, "hit_count", int'(e.inst_b ? hc_b : hc_a), e.cnt);
                cmp(e.tid, "cooling", int'(e.inst_b ? cool_b : cool_a), int'(e.cooling));
                if (e.chk_pos) begin
                    px = bxs[e.slot*11 +: 11];
                    py = bys[e.slot*10 +: 10];
                    cmp(e.tid, "bx", int'(px), e.x);
                    cmp(e.tid, "by", int'(py), e.y);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input exp_t e);
        sb.push_back(e);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        cycle();
    endtask

    task automatic do_probe(input exp_t e);
        sb.push_back(e);
        probe = 1'b1;
        cycle();
        probe = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; tick = 1'b0; fire = 1'b0; block = 1'b0;
        xShooter = 11'sd200; yShooter = 10'sd0;
        xTarget = 11'sd0; yTarget = 10'sd400; targetSquat = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        cycle();

        // Cooldown 4 with fire held: spawns on ticks 0, 5, 10
        fire = 1'b1;
        for (int t = 0; t <= 10; t++) begin
            logic [3:0] al;
            al = (t < 5) ? 4'h1 : ((t < 10) ? 4'h3 : 4'h7);
            do_tick(mk(3, 0, al, 0, 0, (t % 5) != 4, 1, 0, 180 - 8*t, 0));
        end
        fire = 1'b0;

        // Reset in flight with three bullets alive
        rst = 1'b1;
        do_probe(mk(1, 0, 4'h0, 0, 0, 0, 1, 0, 0, 0));
        rst = 1'b0;
        cycle();

        // Spawn offset and first move
        fire = 1'b1;
        do_tick(mk(2, 0, 4'h1, 0, 0, 1, 1, 0, 180, 0));
        fire = 1'b0;
        do_tick(mk(2, 0, 4'h1, 0, 0, 1, 1, 0, 172, 0));

        // No cooldown: block suppresses, then slots fill and a 5th fire is ignored
        do_reset();
        fire = 1'b1;
        block = 1'b1;
        do_tick(mk(4, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0));
        block = 1'b0;
        for (int t = 0; t <= 4; t++) begin
            logic [3:0] al;
            al = (t >= 3) ? 4'hF : 4'((1 << (t + 1)) - 1);
            do_tick(mk(4, 1, al, 0, 0, 0, 1, (t < 4) ? t : 3, (t < 4) ? 180 : 172, 0));
        end
        fire = 1'b0;

        // Standing target at (-100,20): hit on the third move
        do_reset();
        xShooter = -11'sd40; yShooter = 10'sd0;
        xTarget = -11'sd100; yTarget = 10'sd20; targetSquat = 1'b0;
        fire = 1'b1;
        do_tick(mk(5, 0, 4'h1, 0, 0, 1, 1, 0, -60, 0));
        fire = 1'b0;
        do_tick(mk(5, 0, 4'h1, 0, 0, 1, 1, 0, -68, 0));
        do_tick(mk(5, 0, 4'h1, 0, 0, 1, 1, 0, -76, 0));
        do_tick(mk(5, 0, 4'h0, 1, 1, 1, 0, 0, 0, 0));
        do_probe(mk(5, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0));

        // Squatting target: |dy| = 20 is outside the window, bullet passes
        do_reset();
        targetSquat = 1'b1;
        fire = 1'b1;
        do_tick(mk(5, 0, 4'h1, 0, 0, 1, 1, 0, -60, 0));
        fire = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            do_tick(mk(5, 0, 4'h1, 0, 0, t < 4, 1, 0, -60 - 8*t, 0));
        end
        targetSquat = 1'b0;

        // Two bullets entering the hit window on the same tick
        do_reset();
        xTarget = -11'sd100; yTarget = 10'sd0;
        fire = 1'b1;
        xShooter = -11'sd40;
        do_tick(mk(6, 1, 4'h1, 0, 0, 0, 1, 0, -60, 0));
        xShooter = -11'sd48;
        do_tick(mk(6, 1, 4'h3, 0, 0, 0, 1, 1, -68, 0));
        fire = 1'b0;
        do_tick(mk(6, 1, 4'h3, 0, 0, 0, 1, 0, -76, 0));
        do_tick(mk(6, 1, 4'h0, 1, 2, 0, 0, 0, 0, 0));
        do_probe(mk(6, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0));

        // Left edge: -316 stays in play, -320 and -324 are freed without a hit
        do_reset();
        xTarget = 11'sd0; yTarget = 10'sd400;
        fire = 1'b1;
        xShooter = -11'sd276;
        do_tick(mk(6, 1, 4'h1, 0, 0, 0, 1, 0, -296, 0));
        xShooter = -11'sd280;
        do_tick(mk(6, 1, 4'h3, 0, 0, 0, 1, 1, -300, 0));
        fire = 1'b0;
        do_tick(mk(6, 1, 4'h3, 0, 0, 0, 1, 0, -312, 0));
        do_tick(mk(6, 1, 4'h2, 0, 0, 0, 1, 1, -316, 0));
        do_tick(mk(6, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0));

        cycle(); cycle();
        cmp(0, "sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
